// File: rtl/series_seq_arbiter.sv
// series_seq_arbiter: round-robin arbiter and job sequencer sharing one series-evaluation engine.
// Latency: gnt at T, start_cntr T+1, done T+1+nterms_q, rsp_valid T+2+nterms_q+PIPE_LAT.
// Backpressure: rsp_valid/rsp_id held until rsp_ready; no grant is issued while busy.
//
// Ports: req/req_func/req_nterms are per-requester (packed, requester i at slot i);
// gnt is a one-cycle one-hot accept; start_cntr/done/term_cnt talk to the external
// term counter; func_sel drives the coefficient ROM; rsp_* return the tagged result.
// Optional feature macro SEQ_ABORT_EN: when defined, abort ends the job early and the
// response carries rsp_err=1; when undefined, abort is ignored and rsp_err is 0.
module series_seq_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CNTR_DEPTH = 6,
    parameter int FUNC_W     = 3,
    parameter int PIPE_LAT   = 4,
    parameter int MAX_TERMS  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*FUNC_W-1:0]      req_func,
    input  logic [NUM_REQ*CNTR_DEPTH-1:0]  req_nterms,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           busy,
    output logic                           start_cntr,
    output logic                           done,
    input  logic [CNTR_DEPTH-1:0]          term_cnt,
    output logic [FUNC_W-1:0]              func_sel,
    output logic                           rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic                           rsp_err,
    input  logic                           rsp_ready,
    input  logic                           abort
);

    localparam int ID_W = $clog2(NUM_REQ);
    // drain_cnt only needs to reach PIPE_LAT-1
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0]         DRAIN_LAST = DW'(PIPE_LAT - 1);
    localparam logic [CNTR_DEPTH-1:0] MAX_T      = CNTR_DEPTH'(MAX_TERMS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         id_q;
    logic [FUNC_W-1:0]       func_q;
    logic [CNTR_DEPTH-1:0]   nterms_q;
    logic [DW-1:0]           drain_q;

    logic                    pick_found;
    logic [ID_W-1:0]         pick_id;
    logic [ID_W-1:0]         scan_idx;

    // A zero-length job still issues one term; long jobs are capped.
    function automatic logic [CNTR_DEPTH-1:0] clamp_terms(input logic [CNTR_DEPTH-1:0] n);
        if (n == '0)
            return CNTR_DEPTH'(1);
        else if (n > MAX_T)
            return MAX_T;
        else
            return n;
    endfunction

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

`ifdef SEQ_ABORT_EN
    logic err_q;
    logic abort_hit;
`else
    // abort has no function in this build
    logic abort_unused;
    assign abort_unused = abort;
`endif

    always_comb begin
        state_d    = state_q;
        gnt        = '0;
        start_cntr = 1'b0;
        done       = 1'b0;
`ifdef SEQ_ABORT_EN
        abort_hit  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt[pick_id] = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                start_cntr = 1'b1;
                state_d    = S_RUN;
`ifdef SEQ_ABORT_EN
                if (abort) begin
                    done      = 1'b1;
                    abort_hit = 1'b1;
                    state_d   = S_RESP;
                end
`endif
            end
            S_RUN: begin
                if (term_cnt == nterms_q - CNTR_DEPTH'(1)) begin
                    done    = 1'b1;
                    state_d = S_DRAIN;
                end
`ifdef SEQ_ABORT_EN
                // abort skips the drain: results in flight are discarded
                if (abort) begin
                    done      = 1'b1;
                    abort_hit = 1'b1;
                    state_d   = S_RESP;
                end
`endif
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST)
                    state_d = S_RESP;
`ifdef SEQ_ABORT_EN
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Nothing is accepted while reset is asserted.
        if (!rst_n)
            gnt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            func_q   <= '0;
            nterms_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && pick_found) begin
                id_q     <= pick_id;
                rr_ptr_q <= pick_id;
                func_q   <= req_func[int'(pick_id)*FUNC_W +: FUNC_W];
                nterms_q <= clamp_terms(req_nterms[int'(pick_id)*CNTR_DEPTH +: CNTR_DEPTH]);
            end
            if (state_q == S_RUN)
                drain_q <= '0;
            else if (state_q == S_DRAIN)
                drain_q <= drain_q + DW'(1);
        end
    end

`ifdef SEQ_ABORT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state_q == S_RESP && rsp_ready)
            err_q <= 1'b0;
        else if (abort_hit)
            err_q <= 1'b1;
    end
    assign rsp_err = (state_q == S_RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign func_sel  = func_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_valid ? id_q : '0;

endmodule

// File: tb/tb_series_seq_arbiter.sv
// tb_series_seq_arbiter: randomized and directed checks of series_seq_arbiter against a timeline model.
// Latency: model predicts every output each cycle from the grant time and clamped term count.
// Backpressure: rsp_ready is stalled directly and randomly to exercise response hold.
module tb_series_seq_arbiter;

    localparam int N  = 4;
    localparam int CD = 6;
    localparam int FW = 3;
    localparam int PL = 4;
    localparam int MT = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*FW-1:0]   req_func = '0;
    logic [N*CD-1:0]   req_nterms = '0;
    logic [N-1:0]      gnt;
    logic              busy, start_cntr, done;
    logic [CD-1:0]     term_cnt = '0;
    logic [FW-1:0]     func_sel;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic              rsp_err;
    logic              rsp_ready = 1'b0;
    logic              abort = 1'b0;

    series_seq_arbiter #(
        .NUM_REQ(N), .CNTR_DEPTH(CD), .FUNC_W(FW), .PIPE_LAT(PL), .MAX_TERMS(MT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_func(req_func), .req_nterms(req_nterms),
        .gnt(gnt), .busy(busy), .start_cntr(start_cntr), .done(done), .term_cnt(term_cnt),
        .func_sel(func_sel), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .abort(abort)
    );

    always #5 clk = ~clk;

    // External term counter: restarts at 0 the cycle after start_cntr.
    always @(posedge clk) term_cnt <= start_cntr ? '0 : term_cnt + 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit keep_req = 1'b0;

    // Model: a job is described by cycle offsets from its grant.
    bit            m_active = 1'b0;
    int            m_c, m_done_at, m_rsp_at, m_id;
    int            m_last = N - 1;
    bit            m_err;
    logic [FW-1:0] m_fsel = '0;

    logic [N-1:0]  e_gnt, g_saved;
    bit            e_busy, e_start, e_done, e_rv, e_err;
    logic [IW-1:0] e_id;
    logic [13:0]   obs_v, exp_v;

    task automatic model_eval();
        e_gnt = '0; e_busy = 0; e_start = 0; e_done = 0; e_rv = 0; e_err = 0; e_id = '0;
        if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (req[i] && e_gnt == '0) e_gnt[i] = 1'b1;
            end
        end else begin
            e_busy  = 1;
            e_start = (m_c == 1);
`ifdef SEQ_ABORT_EN
            if (abort && m_c <= m_done_at) begin
                m_done_at = m_c; m_rsp_at = m_c + 1; m_err = 1;
            end else if (abort && m_c < m_rsp_at) begin
                m_rsp_at = m_c + 1; m_err = 1;
            end
`endif
            e_done = (m_c == m_done_at);
            e_rv   = (m_c >= m_rsp_at);
            e_err  = e_rv && m_err;
            e_id   = e_rv ? IW'(m_id) : '0;
        end
    endtask

    task automatic model_advance();
        int g, n;
        if (!rst_n) begin
            m_active = 0; m_last = N - 1; m_fsel = '0;
        end else if (!m_active) begin
            if (e_gnt != '0) begin
                g = 0;
                for (int k = 0; k < N; k++) if (e_gnt[k]) g = k;
                n = int'(req_nterms[g*CD +: CD]);
                n = (n == 0) ? 1 : ((n > MT) ? MT : n);
                m_active = 1; m_c = 1; m_id = g; m_last = g;
                m_fsel = req_func[g*FW +: FW];
                m_done_at = 1 + n; m_rsp_at = 2 + n + PL; m_err = 0;
            end
        end else if (e_rv && rsp_ready) begin
            m_active = 0;
        end else begin
            m_c++;
        end
    endtask

    task automatic prep();
        #1;
        model_eval();
        exp_v = {e_gnt, e_busy, e_start, e_done, m_fsel, e_rv, e_id, e_err};
        obs_v = {gnt, busy, start_cntr, done, func_sel, rsp_valid, (rsp_valid ? rsp_id : IW'(0)), rsp_err};
    endtask

    task automatic adv();
        model_advance();
        g_saved = e_gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (!keep_req) req = req & ~g_saved;
    endtask

    task automatic do_reset();
        req = '0; abort = 0; rst_n = 0;
        prep(); adv();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        prep();
        vectors++;
        if (obs_v !== exp_v || obs_v !== 14'h0)
            $display("FAIL reset_state got=%h want=%h", obs_v, exp_v);
        if (obs_v !== exp_v || obs_v !== 14'h0) miscompares++;
        adv();
    endtask

    task automatic test_single();
        int t_g = -100, t_s = -100, t_d = -100, t_r = -100, d_cnt = -1;
        req_func[0 +: FW] = 3'd3; req_nterms[0 +: CD] = 6'd5; rsp_ready = 1; req = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (gnt[0] && t_g < 0) t_g = cyc;
            if (start_cntr) t_s = cyc;
            if (done) begin t_d = cyc; d_cnt = int'(term_cnt); end
            if (rsp_valid && t_r < 0) t_r = cyc;
            adv();
        end
        vectors++;
        if (t_s - t_g != 1 || t_d - t_g != 1 + 5 || t_r - t_g != 2 + 5 + PL || d_cnt != 4) begin
            miscompares++;
            $display("FAIL single_latency start=%0d done=%0d rsp=%0d cnt=%0d want 1 6 %0d 4", t_s - t_g, t_d - t_g, t_r - t_g, d_cnt, 2 + 5 + PL);
        end
    endtask

    task automatic test_fair();
        int q[$];
        do_reset();
        for (int i = 0; i < N; i++) req_nterms[i*CD +: CD] = 6'd2;
        keep_req = 1; rsp_ready = 1; req = 4'b1111;
        for (int k = 0; k < 46; k++) begin
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL fair cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            for (int i = 0; i < N; i++) if (gnt[i]) q.push_back(i);
            adv();
        end
        keep_req = 0; req = '0;
        for (int k = 0; k < 12; k++) begin
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL fair_tail cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            adv();
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (q.size() <= k || q[k] != k % N) begin
                miscompares++;
                $display("FAIL fair_order idx=%0d got=%0d want=%0d", k, (q.size() > k) ? q[k] : -1, k % N);
            end
        end
    endtask

    task automatic test_clamp();
        int dq[$];
        do_reset();
        req_nterms[1*CD +: CD] = 6'd0; req_nterms[2*CD +: CD] = 6'd50; rsp_ready = 1; req = 4'b0110;
        for (int k = 0; k < 58; k++) begin
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL clamp cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (done) dq.push_back(int'(term_cnt));
            adv();
        end
        vectors++;
        if (dq.size() != 2 || dq[0] != 0 || dq[1] != MT - 1) begin
            miscompares++;
            $display("FAIL clamp_done_cnt n=%0d first=%0d second=%0d want 2 0 %0d", dq.size(), (dq.size() > 0) ? dq[0] : -1, (dq.size() > 1) ? dq[1] : -1, MT - 1);
        end
    endtask

    task automatic test_stall();
        int stall = 0, t_hs = -100, t_g2 = -100;
        bit asserted = 0;
        req_nterms[3*CD +: CD] = 6'd3; req_nterms[2*CD +: CD] = 6'd1; rsp_ready = 0; req = 4'b1000;
        for (int k = 0; k < 36; k++) begin
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (rsp_valid && !rsp_ready) stall++;
            if (rsp_valid && rsp_ready && t_hs < 0) t_hs = cyc;
            if (gnt[2] && t_g2 < 0) t_g2 = cyc;
            adv();
            rsp_ready = (stall >= 7);
            if (busy && !asserted) begin req[2] = 1'b1; asserted = 1; end
        end
        vectors++;
        if (t_g2 - t_hs != 1 || stall != 7) begin
            miscompares++;
            $display("FAIL stall_regrant gap=%0d stalls=%0d want 1 7", t_g2 - t_hs, stall);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        do_reset();
        req_nterms[1*CD +: CD] = 6'd8; req_nterms[0 +: CD] = 6'd2; rsp_ready = 1; req = 4'b0010;
        for (int k = 0; k < 40; k++) begin
            if (!hit && busy && !start_cntr && term_cnt == 6'd3) begin
                hit = 1; rst_n = 0; req = 4'b0101;
                prep(); adv();
                rst_n = 1;
                prep(); vectors++;
                if (gnt !== 4'b0001 || busy !== 1'b0 || rsp_valid !== 1'b0 || obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL reset_mid gnt=%b busy=%b vec=%h want gnt=0001 busy=0 vec=%h", gnt, busy, obs_v, exp_v);
                end
                adv();
            end else begin
                prep(); vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_mid_run cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
                adv();
            end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL reset_mid_trigger got=0 want=1"); end
    endtask

    task automatic test_abort();
        bit run_seen = 0, fired = 0, ab_done = 0, err_seen = 0;
        bit want_done, want_err;
`ifdef SEQ_ABORT_EN
        want_done = 1; want_err = 1;
`else
        want_done = 0; want_err = 0;
`endif
        req_nterms[0 +: CD] = 6'd10; rsp_ready = 1; req = 4'b0001;
        for (int k = 0; k < 30; k++) begin
            if (run_seen && !fired && term_cnt == 6'd2) begin abort = 1; fired = 1; end
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL abort cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (abort) ab_done = done;
            if (rsp_valid && rsp_err) err_seen = 1;
            if (start_cntr) run_seen = 1;
            adv();
            abort = 0;
        end
        vectors++;
        if (ab_done != want_done || err_seen != want_err || !fired) begin
            miscompares++;
            $display("FAIL abort_effect done=%0d err=%0d fired=%0d want %0d %0d 1", ab_done, err_seen, fired, want_done, want_err);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 450; k++) begin
            prep(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            adv();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    req_func[i*FW +: FW] = FW'($urandom_range(0, 7));
                    req_nterms[i*CD +: CD] = CD'($urandom_range(0, 40));
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 30) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            abort = ($urandom_range(0, 19) == 0);
        end
        abort = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fair();
        test_clamp();
        test_stall();
        test_reset_mid();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
